// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button event decoder.
package btn_pkg;

   // Timer width; 2**CNT_W must exceed the largest timing constant in use.
   localparam int unsigned CNT_W = 8;

   localparam int unsigned LONG_CYCLES_DEF   = 50;
   localparam int unsigned GAP_CYCLES_DEF    = 20;
   localparam int unsigned REPEAT_CYCLES_DEF = 25;

   typedef enum logic [2:0] {
      StIdle,
      StPress1,
      StGap,
      StPress2,
      StHeld
   } btn_state_e;

endpackage

// File: rtl/event_timer.sv
// Shared gesture timer: clearable, enabled up-counter with a terminal-count compare.
module event_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] tc_val_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear has priority over enable.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button activity into short press, long press and double click
// pulses. Optional auto-repeat while long-held is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_decoder
   import btn_pkg::*;
#(
   parameter int unsigned LONG_CYCLES   = btn_pkg::LONG_CYCLES_DEF,
   parameter int unsigned GAP_CYCLES    = btn_pkg::GAP_CYCLES_DEF,
   parameter int unsigned REPEAT_CYCLES = btn_pkg::REPEAT_CYCLES_DEF,
   parameter int unsigned CNT_W         = btn_pkg::CNT_W
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic in_signal_i,
   input  logic in_signal_enable_i,
   output logic short_press_o,
   output logic long_press_o,
   output logic double_click_o,
   output logic repeat_press_o,
   output logic busy_o
);

   btn_state_e       state_q;
   logic             level_q;
   logic             short_q;
   logic             long_q;
   logic             double_q;
   logic             rise;
   logic             fall;
   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_tc;
   logic [CNT_W-1:0] tc_val;

   // Only strobes that change the tracked level count as edges.
   assign rise = in_signal_enable_i &  in_signal_i & ~level_q;
   assign fall = in_signal_enable_i & ~in_signal_i &  level_q;

   // Terminal count for the current state.
   always_comb begin
      tc_val = CNT_W'(LONG_CYCLES - 1);
      unique case (state_q)
         StGap:   tc_val = CNT_W'(GAP_CYCLES - 1);
         StHeld:  tc_val = CNT_W'(REPEAT_CYCLES - 1);
         default: tc_val = CNT_W'(LONG_CYCLES - 1);
      endcase
   end

   // Timer control: clear on every state change (and while idle), count otherwise.
   always_comb begin
      tmr_clr = 1'b1;
      tmr_en  = 1'b0;
      unique case (state_q)
         StPress1, StPress2: begin
            tmr_clr = fall | tmr_tc;
            tmr_en  = 1'b1;
         end
         StGap: begin
            tmr_clr = rise | tmr_tc;
            tmr_en  = 1'b1;
         end
         StHeld: begin
`ifdef BTN_AUTOREPEAT_EN
            tmr_clr = fall | tmr_tc;
            tmr_en  = 1'b1;
`else
            tmr_clr = 1'b1;
            tmr_en  = 1'b0;
`endif
         end
         default: begin
            tmr_clr = 1'b1;
            tmr_en  = 1'b0;
         end
      endcase
   end

   event_timer #(
      .CNT_W (CNT_W)
   ) u_event_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .tc_val_i (tc_val),
      .tc_o     (tmr_tc)
   );

`ifdef BTN_AUTOREPEAT_EN
   logic repeat_q;
`endif

   // Gesture FSM with registered single-cycle event pulses; strobes win ties with timeouts.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         level_q  <= 1'b0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         repeat_q <= 1'b0;
`endif
      end else begin
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         repeat_q <= 1'b0;
`endif
         if (in_signal_enable_i) begin
            level_q <= in_signal_i;
         end
         case (state_q)
            StIdle: begin
               if (rise) state_q <= StPress1;
            end
            StPress1: begin
               if (fall) begin
                  state_q <= StGap;
               end else if (tmr_tc) begin
                  long_q  <= 1'b1;
                  state_q <= StHeld;
               end
            end
            StGap: begin
               if (rise) begin
                  state_q <= StPress2;
               end else if (tmr_tc) begin
                  short_q <= 1'b1;
                  state_q <= StIdle;
               end
            end
            StPress2: begin
               if (fall) begin
                  double_q <= 1'b1;
                  state_q  <= StIdle;
               end else if (tmr_tc) begin
                  // First click is dropped: the gesture becomes a long press.
                  long_q  <= 1'b1;
                  state_q <= StHeld;
               end
            end
            StHeld: begin
               if (fall) begin
                  state_q <= StIdle;
`ifdef BTN_AUTOREPEAT_EN
               end else if (tmr_tc) begin
                  repeat_q <= 1'b1;
`endif
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign short_press_o  = short_q;
   assign long_press_o   = long_q;
   assign double_click_o = double_q;
   assign busy_o         = (state_q != StIdle);
`ifdef BTN_AUTOREPEAT_EN
   assign repeat_press_o = repeat_q;
`else
   assign repeat_press_o = 1'b0;
`endif

endmodule
